irq_pending_ctrl: RTL and testbench
===================================

Name: irq_pending_ctrl

Overview:
Interrupt pending/mask controller that sits directly upstream of the find-first-one priority encoder in the interrupt path. It edge-detects N raw interrupt lines, latches them into a pending register, and applies a software-writable mask. It drives the masked pending vector into the priority encoder and takes the encoder's 5-bit index back. A request/acknowledge/done state machine presents one interrupt at a time to the CPU, with a stable cause.

Parameters:
N, 32, number of interrupt lines; 1..32 (the encoder index is 5 bits)

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
irq_in  input  N  raw interrupt lines; a rising edge requests service
mask_we  input  1  write strobe for the mask register
mask_wdata  input  N  new mask value; 1 = enabled
first_idx  input  5  index of the lowest set bit of pend_masked, returned by the priority encoder
cpu_ack  input  1  CPU accepts the presented interrupt; valid only in REQ
cpu_done  input  1  CPU finished the handler (eret); valid only in BUSY
pend_masked  output  N  combinational pending & mask; drives the priority encoder
pending_o  output  N  raw pending register, for status readback
irq_req  output  1  registered interrupt request to the CPU
irq_cause  output  5  registered index of the presented/serviced interrupt
irq_active  output  1  registered; high while a handler runs (BUSY)

Behaviour:
- Reset (sync, active-high):
  - irq_prev, pending and irq_cause are all 0; mask is all 1s; state is IDLE; irq_req and irq_active are 0.
  - Reset overrides every other input in the same cycle, including mid-REQ or mid-BUSY.
- Edge detect:
  - edge[k] = irq_in[k] & ~irq_prev[k]; irq_prev <= irq_in every cycle.
  - A line already high in the first cycle after reset therefore counts as an edge.
- Pending register, per bit, each cycle:
  - Set if edge[k].
  - Else cleared if the ack-clear is for bit k (see below).
  - Else held.
  - An edge and a clear on the same bit in the same cycle leave the bit set (set wins).
- Mask:
  - mask <= mask_wdata when mask_we.
  - Masked bits stay pending but are hidden from pend_masked.
  - The new mask affects pend_masked from the next cycle.
- any_pend = OR of pend_masked. first_idx is consumed only when any_pend=1; it is otherwise don't-care.
- FSM states: IDLE, REQ, BUSY.
  - IDLE: if any_pend, go to REQ and set irq_cause <= first_idx; otherwise stay. Latency: an edge sampled at clock edge e0 sets pending at e0; irq_req is high after e1.
  - REQ:
    - irq_req=1; irq_cause is held stable for the whole state and is never re-prioritised.
    - If pend_masked[irq_cause]=0 (masked or withdrawn), go to IDLE with irq_req=0. A cpu_ack in that same cycle is ignored.
    - Else if cpu_ack, go to BUSY and clear pending[irq_cause] (subject to set-wins).
  - BUSY:
    - irq_req=0, irq_active=1, irq_cause held.
    - Further edges still accumulate in pending; there is no nesting.
    - On cpu_done, go to IDLE. A fresh arbitration can start on the following cycle.
- Protocol errors:
  - cpu_ack outside REQ and cpu_done outside BUSY are ignored with no side effects.
  - cpu_ack and cpu_done asserted together in REQ count as ack only.
- Outputs irq_req and irq_active are decoded from registered state, so they carry no combinational paths from inputs. pend_masked is purely combinational from registers.
- All arithmetic is bitwise. irq_cause is never greater than N-1 when irq_req=1.

Test Plan:
- Reset, then pulse irq_in[5] for 1 cycle → pending_o=0x20 after the edge; irq_req=1 and irq_cause=5 one cycle later; cpu_ack → pending_o=0, irq_active=1; cpu_done → back to IDLE, irq_req stays 0.
- Edges on bits 3 and 9 in the same cycle → irq_cause=3. Ack then done → next REQ presents irq_cause=9.
- mask_wdata=0xFFFFFFF7 written while in REQ with cause 3 → withdraw to IDLE; pending_o bit 3 stays 1; REQ restarts with cause 9 if bit 9 is pending.
- In REQ for cause 4, new edge on bit 4 in the same cycle as cpu_ack → BUSY, pending_o bit 4 still 1; after cpu_done, REQ again with cause 4.
- irq_in[0] held high through reset → after reset release, pending bit 0 set on the first cycle; irq_in held high afterwards produces no second set after ack.
- Assert reset during BUSY with pending=0x0000_0102 → next cycle: pending_o=0, irq_req=0, irq_active=0, irq_cause=0, mask=0xFFFFFFFF; cpu_ack and cpu_done pulsed in IDLE → no change.

Source files
------------

// File: rtl/irq_pending_ctrl_if.sv
// CPU-side interrupt handshake: the controller (master) presents one interrupt,
// and the CPU (slave) answers with ack and then done.
interface irq_pending_ctrl_if;
  logic       irq_req;
  logic [4:0] irq_cause;
  logic       irq_active;
  logic       cpu_ack;
  logic       cpu_done;

  modport master (
    output irq_req,
    output irq_cause,
    output irq_active,
    input  cpu_ack,
    input  cpu_done
  );

  modport slave (
    input  irq_req,
    input  irq_cause,
    input  irq_active,
    output cpu_ack,
    output cpu_done
  );
endinterface

// File: rtl/irq_pending_ctrl.sv
// Interrupt pending/mask controller: edge-detects raw lines into a pending register,
// masks them for an external priority encoder and presents one cause at a time.
module irq_pending_ctrl #(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         irq_in,
  input  logic                 mask_we,
  input  logic [N-1:0]         mask_wdata,
  input  logic [4:0]           first_idx,
  output logic [N-1:0]         pend_masked,
  output logic [N-1:0]         pending_o,
  irq_pending_ctrl_if.master   cpu,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  state_t       state_q;
  logic [N-1:0] irq_prev_q;
  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] mask_q;
  logic [4:0]   cause_q;
  logic         irq_req_q;
  logic         irq_active_q;

  logic [N-1:0] edge_w;
  logic [N-1:0] cause_hot;
  logic [N-1:0] clr_vec;
  logic         any_pend;
  logic         cause_live;
  logic         take_ack;

  // Handshake: irq_req is high only in REQ and cpu_ack is honoured only there;
  // cpu_done is honoured only in BUSY. Anything else on ack/done is ignored.
  assign edge_w      = irq_in & ~irq_prev_q;
  assign pend_masked = pending_q & mask_q;
  assign any_pend    = |pend_masked;
  assign cause_hot   = N'(1) << cause_q;
  assign cause_live  = |(pend_masked & cause_hot);
  assign take_ack    = (state_q == ST_REQ) && cause_live && cpu.cpu_ack;
  assign clr_vec     = take_ack ? cause_hot : '0;
  // A new edge on the bit being acknowledged keeps it pending.
  assign pending_d   = edge_w | (pending_q & ~clr_vec);

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_prev_q   <= '0;
      pending_q    <= '0;
      mask_q       <= '1;
      state_q      <= ST_IDLE;
      cause_q      <= '0;
      irq_req_q    <= 1'b0;
      irq_active_q <= 1'b0;
    end else begin
      irq_prev_q <= irq_in;
      pending_q  <= pending_d;
      if (mask_we) mask_q <= mask_wdata;
      case (state_q)
        ST_IDLE: begin
          if (any_pend) begin
            state_q   <= ST_REQ;
            cause_q   <= first_idx;
            irq_req_q <= 1'b1;
          end
        end
        ST_REQ: begin
          if (!cause_live) begin
            state_q   <= ST_IDLE;
            irq_req_q <= 1'b0;
          end else if (cpu.cpu_ack) begin
            state_q      <= ST_BUSY;
            irq_req_q    <= 1'b0;
            irq_active_q <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (cpu.cpu_done) begin
            state_q      <= ST_IDLE;
            irq_active_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          irq_req_q    <= 1'b0;
          irq_active_q <= 1'b0;
        end
      endcase
    end
  end

  assign pending_o      = pending_q;
  assign cpu.irq_req    = irq_req_q;
  assign cpu.irq_cause  = cause_q;
  assign cpu.irq_active = irq_active_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl with a behavioural find-first-one encoder.
module tb_irq_pending_ctrl;

  localparam int N = 32;

  logic         clk;
  logic         reset;
  logic [N-1:0] irq_in;
  logic         mask_we;
  logic [N-1:0] mask_wdata;
  logic [4:0]   first_idx;
  logic [N-1:0] pend_masked;
  logic [N-1:0] pending_o;
  logic [1:0]   state_o;

  int n_checks = 0;
  int n_pass   = 0;

  irq_pending_ctrl_if cpu_if ();

  irq_pending_ctrl #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .first_idx  (first_idx),
    .pend_masked(pend_masked),
    .pending_o  (pending_o),
    .cpu        (cpu_if.master),
    .state_o    (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // encoder model: lowest set bit of pend_masked
  always_comb begin
    first_idx = 5'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_masked[i]) first_idx = 5'(i);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic pulse_ack();
    cpu_if.cpu_ack = 1'b1;
    step();
    cpu_if.cpu_ack = 1'b0;
  endtask

  task automatic pulse_done();
    cpu_if.cpu_done = 1'b1;
    step();
    cpu_if.cpu_done = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
    cpu_if.cpu_ack = 1'b0; cpu_if.cpu_done = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_pending", pending_o, 32'h0);
    check("rst_req", 32'(cpu_if.irq_req), 32'h0);
    check("rst_active", 32'(cpu_if.irq_active), 32'h0);
    check("rst_cause", 32'(cpu_if.irq_cause), 32'h0);
    check("rst_state", 32'(state_o), 32'h0);

    // single line 5
    irq_in = 32'h20; step(); irq_in = '0;
    check("t1_pending", pending_o, 32'h20);
    check("t1_req_early", 32'(cpu_if.irq_req), 32'h0);
    step();
    check("t1_req", 32'(cpu_if.irq_req), 32'h1);
    check("t1_cause", 32'(cpu_if.irq_cause), 32'd5);
    pulse_ack();
    check("t1_pend_clr", pending_o, 32'h0);
    check("t1_active", 32'(cpu_if.irq_active), 32'h1);
    check("t1_req_busy", 32'(cpu_if.irq_req), 32'h0);
    pulse_done();
    check("t1_idle", 32'(state_o), 32'h0);
    check("t1_active_off", 32'(cpu_if.irq_active), 32'h0);
    step();
    check("t1_req_stays0", 32'(cpu_if.irq_req), 32'h0);

    // lines 3 and 9 together
    irq_in = 32'h208; step(); irq_in = '0;
    check("t2_pending", pending_o, 32'h208);
    step();
    check("t2_cause3", 32'(cpu_if.irq_cause), 32'd3);
    pulse_ack();
    check("t2_pend_after_ack", pending_o, 32'h200);
    pulse_done();
    step();
    check("t2_req9", 32'(cpu_if.irq_req), 32'h1);
    check("t2_cause9", 32'(cpu_if.irq_cause), 32'd9);
    pulse_ack(); pulse_done(); step();
    check("t2_pend_empty", pending_o, 32'h0);

    // mask withdraw
    irq_in = 32'h208; step(); irq_in = '0; step();
    check("t3_cause3", 32'(cpu_if.irq_cause), 32'd3);
    mask_we = 1'b1; mask_wdata = 32'hFFFF_FFF7; step(); mask_we = 1'b0;
    check("t3_pmask", pend_masked, 32'h200);
    step();
    check("t3_withdrawn", 32'(cpu_if.irq_req), 32'h0);
    check("t3_state_idle", 32'(state_o), 32'h0);
    check("t3_pend_kept", pending_o, 32'h208);
    step();
    check("t3_req9", 32'(cpu_if.irq_req), 32'h1);
    check("t3_cause9", 32'(cpu_if.irq_cause), 32'd9);
    pulse_ack();
    mask_we = 1'b1; mask_wdata = 32'hFFFF_FFFF;
    pulse_done();
    mask_we = 1'b0;
    step();
    check("t3_cause3_again", 32'(cpu_if.irq_cause), 32'd3);
    check("t3_req_again", 32'(cpu_if.irq_req), 32'h1);
    pulse_ack(); pulse_done(); step();
    check("t3_pend_empty", pending_o, 32'h0);

    // set wins over ack clear on line 4
    irq_in = 32'h10; step(); irq_in = '0; step();
    check("t4_cause4", 32'(cpu_if.irq_cause), 32'd4);
    cpu_if.cpu_ack = 1'b1; irq_in = 32'h10; step();
    cpu_if.cpu_ack = 1'b0; irq_in = '0;
    check("t4_busy", 32'(state_o), 32'h2);
    check("t4_pend_kept", pending_o, 32'h10);
    pulse_done(); step();
    check("t4_req_again", 32'(cpu_if.irq_req), 32'h1);
    check("t4_cause_again", 32'(cpu_if.irq_cause), 32'd4);
    pulse_ack(); pulse_done(); step();
    check("t4_pend_empty", pending_o, 32'h0);

    // line 0 held through reset
    reset = 1'b1; irq_in = 32'h1; step(); step(); reset = 1'b0;
    check("t5_pend_in_reset", pending_o, 32'h0);
    step();
    check("t5_pend_first", pending_o, 32'h1);
    step();
    check("t5_cause0", 32'(cpu_if.irq_cause), 32'd0);
    pulse_ack(); step(); step();
    check("t5_no_reset", pending_o, 32'h0);
    pulse_done(); step();
    check("t5_idle", 32'(cpu_if.irq_req), 32'h0);
    irq_in = '0; step();

    // reset during BUSY with pending 0x102 and mask cleared
    irq_in = 32'h102; step(); irq_in = '0; step();
    check("t6_cause1", 32'(cpu_if.irq_cause), 32'd1);
    pulse_ack();
    mask_we = 1'b1; mask_wdata = 32'h0;
    irq_in = 32'h2; step(); irq_in = '0; mask_we = 1'b0;
    check("t6_pend", pending_o, 32'h102);
    check("t6_active", 32'(cpu_if.irq_active), 32'h1);
    reset = 1'b1; step(); reset = 1'b0;
    check("t6_pend_rst", pending_o, 32'h0);
    check("t6_req_rst", 32'(cpu_if.irq_req), 32'h0);
    check("t6_active_rst", 32'(cpu_if.irq_active), 32'h0);
    check("t6_cause_rst", 32'(cpu_if.irq_cause), 32'h0);
    cpu_if.cpu_ack = 1'b1; cpu_if.cpu_done = 1'b1; step();
    cpu_if.cpu_ack = 1'b0; cpu_if.cpu_done = 1'b0;
    check("t6_ackdone_idle", 32'(state_o), 32'h0);
    check("t6_ackdone_pend", pending_o, 32'h0);
    irq_in = 32'h8000_0001; step(); irq_in = '0;
    check("t6_mask_ones", pend_masked, 32'h8000_0001);
    step();
    check("t6_cause0", 32'(cpu_if.irq_cause), 32'd0);
    cpu_if.cpu_ack = 1'b1; cpu_if.cpu_done = 1'b1; step();
    cpu_if.cpu_ack = 1'b0; cpu_if.cpu_done = 1'b0;
    check("t6_ack_only", 32'(state_o), 32'h2);
    pulse_done(); step();
    check("t6_cause31", 32'(cpu_if.irq_cause), 32'd31);
    check("t6_req31", 32'(cpu_if.irq_req), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
